sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - multi-client arbiter in front of a single asynchronous SRAM port
module sram_port_arbiter #(
    parameter int NUM_CLIENTS   = 2,
    parameter int ADDR_WIDTH    = 20,
    parameter int DATA_WIDTH    = 32,
    parameter int ACCESS_CYCLES = 2,
    parameter int ARB_MODE      = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS-1:0]            req_valid,
    input  logic [NUM_CLIENTS-1:0]            req_we,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_CLIENTS-1:0]            req_ready,
    output logic [NUM_CLIENTS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic [ADDR_WIDTH-1:0]             sram_addr,
    inout  wire  [DATA_WIDTH-1:0]             sram_data,
    output logic                              sram_ce_n,
    output logic                              sram_oe_n,
    output logic                              sram_we_n
);

    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [NUM_CLIENTS-1:0] ONE      = NUM_CLIENTS'(1);
    localparam logic [IDX_W-1:0]       TOP_IDX  = IDX_W'(NUM_CLIENTS - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [IDX_W-1:0]         last_grant;
    logic [IDX_W-1:0]         sel_idx;
    logic                     sel_found;
    logic                     sel_we;
    logic [ADDR_WIDTH-1:0]    sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;
    logic [NUM_CLIENTS-1:0]   vshift;
    logic [NUM_CLIENTS-1:0]   weshift;
    int                       cand;
    logic [IDX_W-1:0]         lat_client;
    logic                     lat_we;
    logic [DATA_WIDTH-1:0]    lat_wdata;
    logic                     data_oe;
    logic                     accept;
    logic                     last_cycle;

    // Pick one pending client: round-robin from last_grant+1, or lowest index wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        vshift    = '0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
                vshift = req_valid >> i;
                if (vshift[0]) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= NUM_CLIENTS; k++) begin
                cand = int'(last_grant) + k;
                if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
                vshift = req_valid >> cand;
                if (!sel_found && vshift[0]) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'(cand);
                end
            end
        end
    end

    // Extract the selected client's request fields from the packed buses.
    always_comb begin
        weshift   = req_we >> sel_idx;
        sel_we    = weshift[0];
        sel_addr  = ADDR_WIDTH'(req_addr >> (int'(sel_idx) * ADDR_WIDTH));
        sel_wdata = DATA_WIDTH'(req_wdata >> (int'(sel_idx) * DATA_WIDTH));
    end

    assign accept     = (state == IDLE) && sel_found;
    assign last_cycle = (state == ACCESS) && (cnt == LAST_CNT);

    // Next state, acceptance strobe and SRAM control decode.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        data_oe   = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = ACCESS;
                    if (!rst) req_ready = ONE << sel_idx;
                end
            end
            ACCESS: begin
                sram_ce_n = 1'b0;
                if (lat_we) begin
                    data_oe   = 1'b1;
                    // Last write cycle releases we_n so the data is held past its rising edge.
                    sram_we_n = (ACCESS_CYCLES == 1) ? 1'b0 : (cnt == LAST_CNT);
                end else begin
                    sram_oe_n = 1'b0;
                end
                if (cnt == LAST_CNT) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sram_data = data_oe ? lat_wdata : {DATA_WIDTH{1'bz}};

    // State register, request latch, access counter and response generation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= TOP_IDX;
            lat_client <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            sram_addr  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= '0;
            if (accept) begin
                lat_client <= sel_idx;
                lat_we     <= sel_we;
                lat_wdata  <= sel_wdata;
                sram_addr  <= sel_addr;
                last_grant <= sel_idx;
                cnt        <= '0;
            end else if (last_cycle) begin
                cnt       <= '0;
                rsp_valid <= ONE << lat_client;
                if (!lat_we) rsp_rdata <= sram_data;
            end else if (state == ACCESS) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: 3 clients, 2-cycle access, round-robin
    logic [2:0]  a_valid = '0;
    logic [2:0]  a_we = '0;
    logic [59:0] a_addr = '0;
    logic [95:0] a_wdata = '0;
    logic [2:0]  a_ready;
    logic [2:0]  a_rsp;
    logic [31:0] a_rdata;
    logic [19:0] a_saddr;
    wire  [31:0] a_sdata;
    logic        a_ce_n, a_oe_n, a_we_n;

    // DUT B: 2 clients, 3-cycle access, fixed priority
    logic [1:0]  b_valid = '0;
    logic [1:0]  b_we = '0;
    logic [39:0] b_addr = '0;
    logic [63:0] b_wdata = '0;
    logic [1:0]  b_ready;
    logic [1:0]  b_rsp;
    logic [31:0] b_rdata;
    logic [19:0] b_saddr;
    wire  [31:0] b_sdata;
    logic        b_ce_n, b_oe_n, b_we_n;

    sram_port_arbiter #(.NUM_CLIENTS(3), .ADDR_WIDTH(20), .DATA_WIDTH(32),
                        .ACCESS_CYCLES(2), .ARB_MODE(0)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_we(a_we), .req_addr(a_addr),
        .req_wdata(a_wdata), .req_ready(a_ready), .rsp_valid(a_rsp), .rsp_rdata(a_rdata),
        .sram_addr(a_saddr), .sram_data(a_sdata), .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n),
        .sram_we_n(a_we_n));

    sram_port_arbiter #(.NUM_CLIENTS(2), .ADDR_WIDTH(20), .DATA_WIDTH(32),
                        .ACCESS_CYCLES(3), .ARB_MODE(1)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr),
        .req_wdata(b_wdata), .req_ready(b_ready), .rsp_valid(b_rsp), .rsp_rdata(b_rdata),
        .sram_addr(b_saddr), .sram_data(b_sdata), .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n),
        .sram_we_n(b_we_n));

    // SRAM models
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem_a[i] <= 32'hA5000000 | 32'(i);
            mem_a[16] <= 32'hDEADBEEF;
        end else if (!a_ce_n && !a_we_n) begin
            mem_a[a_saddr[9:0]] <= a_sdata;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem_b[i] <= 32'h5B000000 | 32'(i);
        end else if (!b_ce_n && !b_we_n) begin
            mem_b[b_saddr[9:0]] <= b_sdata;
        end
    end

    assign a_sdata = (!a_ce_n && !a_oe_n) ? mem_a[a_saddr[9:0]] : 32'bz;
    assign b_sdata = (!b_ce_n && !b_oe_n) ? mem_b[b_saddr[9:0]] : 32'bz;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          client;
        logic        we;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    logic [19:0] mon_addr;

    // Scoreboard: push on acceptance, pop and compare on completion
    always @(negedge clk) begin
        if (rst) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (a_ready != 0) begin
                chk("a_ready_onehot", 64'($onehot(a_ready)), 1);
                ea.client = 0;
                for (int i = 0; i < 3; i++) if (a_ready[i]) ea.client = i;
                ea.we    = a_we[ea.client];
                mon_addr = a_addr[ea.client*20 +: 20];
                ea.rdata = mem_a[mon_addr[9:0]];
                ea.due   = cyc + 3;
                q_a.push_back(ea);
            end
            if (a_rsp != 0) begin
                if (q_a.size() == 0) chk("a_rsp_unexpected", a_rsp, 0);
                else begin
                    ea = q_a.pop_front();
                    chk("a_rsp_client", a_rsp, 3'b001 << ea.client);
                    chk("a_rsp_latency", cyc, ea.due);
                    if (!ea.we) chk("a_rsp_rdata", a_rdata, ea.rdata);
                end
            end
            if (b_ready != 0) begin
                chk("b_ready_onehot", 64'($onehot(b_ready)), 1);
                eb.client = b_ready[1] ? 1 : 0;
                eb.we    = b_we[eb.client];
                mon_addr = b_addr[eb.client*20 +: 20];
                eb.rdata = mem_b[mon_addr[9:0]];
                eb.due   = cyc + 4;
                q_b.push_back(eb);
            end
            if (b_rsp != 0) begin
                if (q_b.size() == 0) chk("b_rsp_unexpected", b_rsp, 0);
                else begin
                    eb = q_b.pop_front();
                    chk("b_rsp_client", b_rsp, 2'b01 << eb.client);
                    chk("b_rsp_latency", cyc, eb.due);
                    if (!eb.we) chk("b_rsp_rdata", b_rdata, eb.rdata);
                end
            end
        end
    end

    task automatic wait_b_grant(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (b_ready != 0) ok = 1'b1;
        end
    endtask

    int g_client[$];
    int g_cyc[$];
    int n0;
    bit ok;

    initial begin
        // reset state, with requests pending to prove req_ready is gated
        a_valid = 3'b111;
        b_valid = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_a_rsp", a_rsp, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_a_saddr", a_saddr, 0);
        chk("rst_a_ctl", {a_ce_n, a_oe_n, a_we_n}, 3'b111);
        chk("rst_a_data_z", 64'(a_sdata === 32'bz), 1);

        // round-robin under continuous load
        @(posedge clk); #1;
        rst = 1'b0;
        b_valid = 2'b00;
        a_we = 3'b000;
        a_addr = {20'h00022, 20'h00021, 20'h00020};
        for (int t = 0; t < 60 && g_client.size() < 6; t++) begin
            @(negedge clk);
            if (a_ready != 0) begin
                g_client.push_back(a_ready[2] ? 2 : (a_ready[1] ? 1 : 0));
                g_cyc.push_back(cyc);
            end
        end
        @(posedge clk); #1;
        a_valid = 3'b000;
        chk("rr_count", g_client.size(), 6);
        for (int i = 0; i < g_client.size(); i++) begin
            chk("rr_order", g_client[i], i % 3);
            if (i > 0) chk("rr_spacing", g_cyc[i] - g_cyc[i-1], 3);
        end
        repeat (4) @(negedge clk);

        // single read, client 1, 2-cycle access
        @(posedge clk); #1;
        a_valid = 3'b010;
        a_addr[39:20] = 20'h00010;
        @(negedge clk);
        chk("rd_ready", a_ready, 3'b010);
        @(posedge clk); #1;
        a_valid = 3'b000;
        a_addr[39:20] = 20'h003FF;
        @(negedge clk);
        chk("rd_c1_ctl", {a_ce_n, a_oe_n, a_we_n}, 3'b001);
        chk("rd_c1_addr", a_saddr, 20'h00010);
        chk("rd_c1_ready", a_ready, 0);
        @(negedge clk);
        chk("rd_c2_ctl", {a_ce_n, a_oe_n, a_we_n}, 3'b001);
        chk("rd_c2_rsp", a_rsp, 0);
        @(negedge clk);
        chk("rd_c3_rsp", a_rsp, 3'b010);
        chk("rd_c3_rdata", a_rdata, 32'hDEADBEEF);
        chk("rd_c3_ctl", {a_ce_n, a_oe_n, a_we_n}, 3'b111);

        // B: read addr 5 to load rsp_rdata, then a 3-cycle write
        @(posedge clk); #1;
        b_valid = 2'b10;
        b_we = 2'b00;
        b_addr[39:20] = 20'h00005;
        wait_b_grant(ok);
        chk("b_rd5_grant", ok, 1);
        @(posedge clk); #1;
        b_valid = 2'b00;
        repeat (5) @(negedge clk);
        chk("b_rd5_data", b_rdata, 32'h5B000005);

        @(posedge clk); #1;
        b_valid = 2'b01;
        b_we = 2'b01;
        b_addr[19:0] = 20'h00100;
        b_wdata[31:0] = 32'h12345678;
        @(negedge clk);
        chk("wr_ready", b_ready, 2'b01);
        @(posedge clk); #1;
        b_valid = 2'b00;
        b_wdata[31:0] = 32'h0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("wr_we_n", b_we_n, (c == 3) ? 1 : 0);
            chk("wr_ce_oe", {b_ce_n, b_oe_n}, 2'b01);
            chk("wr_data", b_sdata, 32'h12345678);
        end
        @(negedge clk);
        chk("wr_rsp", b_rsp, 2'b01);
        chk("wr_rdata_kept", b_rdata, 32'h5B000005);
        chk("wr_mem", mem_b[256], 32'h12345678);
        chk("wr_idle_ctl", {b_ce_n, b_oe_n, b_we_n}, 3'b111);
        chk("wr_idle_z", 64'(b_sdata === 32'bz), 1);

        // read the written word back through client 1
        @(posedge clk); #1;
        b_we = 2'b00;
        b_valid = 2'b10;
        b_addr[39:20] = 20'h00100;
        wait_b_grant(ok);
        chk("rdback_grant", ok, 1);
        @(posedge clk); #1;
        b_valid = 2'b00;
        repeat (5) @(negedge clk);
        chk("rdback_data", b_rdata, 32'h12345678);

        // fixed priority: client 0 keeps winning until it withdraws
        @(posedge clk); #1;
        b_valid = 2'b11;
        b_addr = {20'h00002, 20'h00001};
        n0 = 0;
        for (int t = 0; t < 40 && n0 < 3; t++) begin
            @(negedge clk);
            if (b_ready != 0) begin
                chk("fp_win0", b_ready, 2'b01);
                n0++;
            end
        end
        chk("fp_n0", n0, 3);
        @(posedge clk); #1;
        b_valid = 2'b10;
        wait_b_grant(ok);
        chk("fp_got1", ok, 1);
        chk("fp_then1", b_ready, 2'b10);
        @(posedge clk); #1;
        b_valid = 2'b00;
        repeat (6) @(negedge clk);

        // reset during the first cycle of a write
        @(posedge clk); #1;
        a_valid = 3'b001;
        a_we = 3'b001;
        a_addr[19:0] = 20'h00030;
        a_wdata[31:0] = 32'hCAFEF00D;
        @(negedge clk);
        chk("rm_ready", a_ready, 3'b001);
        @(posedge clk); #1;
        a_valid = 3'b000;
        chk("rm_pre_we_n", a_we_n, 0);
        #2 rst = 1'b1;
        #1;
        chk("rm_ctl", {a_ce_n, a_oe_n, a_we_n}, 3'b111);
        chk("rm_z", 64'(a_sdata === 32'bz), 1);
        repeat (2) begin
            @(negedge clk);
            chk("rm_rsp_in_rst", a_rsp, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("rm_no_rsp", a_rsp, 0);
            chk("rm_idle_ce_n", a_ce_n, 1);
        end

        chk("a_sb_empty", q_a.size(), 0);
        chk("b_sb_empty", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
